// File: rtl/dmem_responder_if.sv
// CPU data-memory bus: chip select, read/write strobes, byte address, write data
// and the combinational read-data return path.
interface dmem_responder_if;
  logic        DM_CS;
  logic        DM_R;
  logic        DM_W;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata;

  modport master (output DM_CS, DM_R, DM_W, maddr, mwdata, input  mrdata);
  modport slave  (input  DM_CS, DM_R, DM_W, maddr, mwdata, output mrdata);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 16-byte MMIO window holding the LED,
// cycle counter, compare timer and sticky status. Reads are same-cycle, writes land at the edge.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] DM_BASE    = 32'h1001_0000,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [15:0]       led,
  output logic              irq,
  output logic              err
);
  localparam int AW        = ADDR_WIDTH;
  localparam int RAM_WORDS = 1 << AW;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CYCLE  = 2'd1;
  localparam logic [1:0] OFF_TCMP   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [15:0]   led_q, led_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   tcmp_q, tcmp_d;
  logic          expired_q, expired_d;
  logic          err_q, err_d;

  logic          ram_hit, io_hit, access, bad, good_wr, ram_we, timer_hit;
  logic [AW-1:0] idx;
  logic [1:0]    io_off, clr;
  logic [31:0]   rd_word, rd_data;

  always_comb begin
    ram_hit   = bus.maddr[31:AW+2] == DM_BASE[31:AW+2];
    io_hit    = bus.maddr[31:4] == IO_BASE[31:4];
    idx       = bus.maddr[AW+1:2];
    io_off    = bus.maddr[3:2];
    access    = bus.DM_CS & (bus.DM_R | bus.DM_W);
    bad       = access & ((bus.maddr[1:0] != 2'b00) | !(ram_hit | io_hit));
    good_wr   = bus.DM_CS & bus.DM_W & !bad;
    ram_we    = good_wr & ram_hit;
    timer_hit = (tcmp_q != 32'h0) && (cycle_q == tcmp_q);

    rd_word = 32'h0;
    if (ram_hit) begin
      rd_word = ram_q[idx];
    end else if (io_hit) begin
      case (io_off)
        OFF_LED:    rd_word = {16'h0, led_q};
        OFF_CYCLE:  rd_word = cycle_q;
        OFF_TCMP:   rd_word = tcmp_q;
        default:    rd_word = {30'h0, err_q, expired_q};
      endcase
    end
    rd_data = (bus.DM_CS & bus.DM_R & !bad) ? rd_word : 32'h0;

    led_d   = led_q;
    tcmp_d  = tcmp_q;
    cycle_d = cycle_q + 32'd1;
    clr     = 2'b00;
    if (good_wr && io_hit) begin
      case (io_off)
        OFF_LED:    led_d  = bus.mwdata[15:0];
        OFF_TCMP:   tcmp_d = bus.mwdata;
        OFF_STATUS: clr    = bus.mwdata[1:0];
        default:    ;
      endcase
    end
    // A set event in the same cycle as a write-1-to-clear leaves the flag at 1.
    expired_d = timer_hit | (expired_q & !clr[0]);
    err_d     = bad       | (err_q     & !clr[1]);
  end

  assign bus.mrdata = rd_data;
  assign led        = led_q;
  assign irq        = expired_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      cycle_q   <= '0;
      tcmp_q    <= '0;
      expired_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      tcmp_q    <= tcmp_d;
      expired_q <= expired_d;
      err_q     <= err_d;
    end
  end

  // RAM keeps its contents through reset but refuses writes while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) ram_q[idx] <= bus.mwdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: per-feature tasks, expected read data queued at drive time
// and popped when the combinational read result is sampled.
module tb_dmem_responder;
  localparam logic [31:0] IO = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] led;
  logic irq, err;
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc_m = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  dmem_responder_if bus();

  dmem_responder dut (
    .clk(clk), .reset(rst), .bus(bus), .led(led), .irq(irq), .err(err)
  );

  always #5 clk = ~clk;

  // Model of the free-running counter: the CYCLE value seen between edges.
  always @(posedge clk) cyc_m <= rst ? 0 : cyc_m + 1;

  task automatic step(input logic cs, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.DM_CS = cs; bus.DM_R = r; bus.DM_W = w; bus.maddr = a; bus.mwdata = d;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.DM_CS = 1'b0; bus.DM_R = 1'b0; bus.DM_W = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    #1;
    n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL reset_led: got %h want 0000", led); end
    n_cmp++; if (irq !== 1'b0)  begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (err !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    step(1, 1, 0, IO + 32'h4, 0); exp_q.push_back(32'h1);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL reset_cycle: got %h want %h", bus.mrdata, exp); end
  endtask

  task automatic test_ram();
    step(1, 0, 1, 32'h1001_0010, 32'hDEAD_BEEF);
    step(1, 1, 0, 32'h1001_0010, 0); exp_q.push_back(32'hDEAD_BEEF);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL ram_load: got %h want %h", bus.mrdata, exp); end
    step(1, 1, 1, 32'h1001_0010, 32'h1234); exp_q.push_back(32'hDEAD_BEEF);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL ram_rw_prewrite: got %h want %h", bus.mrdata, exp); end
    step(1, 1, 0, 32'h1001_0010, 0); exp_q.push_back(32'h0000_1234);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL ram_rw_after: got %h want %h", bus.mrdata, exp); end
    // Top word of the RAM, then a read with chip select low must return zero.
    step(1, 0, 1, 32'h1001_1FFC, 32'hA5A5_0F0F);
    step(1, 1, 0, 32'h1001_1FFC, 0); exp_q.push_back(32'hA5A5_0F0F);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL ram_top: got %h want %h", bus.mrdata, exp); end
    step(0, 1, 0, 32'h1001_1FFC, 0); exp_q.push_back(32'h0);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL cs_low_read: got %h want %h", bus.mrdata, exp); end
  endtask

  task automatic test_led();
    step(1, 0, 1, IO, 32'h0001_ABCD);
    step(1, 1, 0, IO, 0); exp_q.push_back(32'h0000_ABCD);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (led !== 16'hABCD) begin n_bad++; $display("FAIL led_out: got %h want abcd", led); end
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL led_read: got %h want %h", bus.mrdata, exp); end
    step(1, 0, 1, IO + 32'h4, 32'h0BAD_0000);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL cycle_ro_err: got %b want 0", err); end
  endtask

  task automatic test_timer();
    int unsigned target;
    int k;
    apply_reset(2);
    step(1, 0, 1, IO + 32'h8, 32'd20);
    for (k = 0; k < 100 && cyc_m != 20; k++) idle();
    #1;
    n_cmp++; if (k >= 100) begin n_bad++; $display("FAIL timer_wait20: got timeout want cycle 20"); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL timer_pre: got %b want 0", irq); end
    step(1, 1, 0, IO + 32'hC, 0); exp_q.push_back(32'h1);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL timer_fire: got %b want 1", irq); end
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL status_read: got %h want %h", bus.mrdata, exp); end
    step(1, 0, 1, IO + 32'hC, 32'h1);
    idle(); #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL timer_clear: got %b want 0", irq); end
    target = cyc_m + 6;
    step(1, 0, 1, IO + 32'h8, target);
    for (k = 0; k < 100 && cyc_m != target - 1; k++) idle();
    step(1, 0, 1, IO + 32'hC, 32'h1);
    #1;
    n_cmp++; if (cyc_m != target) begin n_bad++; $display("FAIL timer_align: got %0d want %0d", cyc_m, target); end
    idle(); #1;
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear: got %b want 1", irq); end
  endtask

  task automatic test_bad_access();
    step(1, 0, 1, 32'h1001_0000, 32'hCAFE_F00D);
    step(1, 1, 0, 32'h1001_0002, 0); exp_q.push_back(32'h0);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL misalign_read: got %h want %h", bus.mrdata, exp); end
    step(1, 0, 1, 32'h1001_0002, 32'h0);
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err); end
    step(1, 1, 0, 32'h1001_0000, 0); exp_q.push_back(32'hCAFE_F00D);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL ram_unchanged: got %h want %h", bus.mrdata, exp); end
    step(1, 0, 1, IO + 32'hC, 32'h2);
    idle(); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
    step(1, 1, 0, 32'h2000_0000, 0); exp_q.push_back(32'h0);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL unmapped_read: got %h want %h", bus.mrdata, exp); end
    idle(); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL unmapped_err: got %b want 1", err); end
  endtask

  task automatic test_reset_during_store();
    step(1, 0, 1, 32'h1001_0020, 32'h1111_1111);
    step(1, 0, 1, IO, 32'h5555);
    idle(); #1;
    n_cmp++; if (led !== 16'h5555) begin n_bad++; $display("FAIL led_pre: got %h want 5555", led); end
    @(negedge clk); rst = 1'b1;
    bus.DM_CS = 1; bus.DM_R = 1; bus.DM_W = 1; bus.maddr = 32'h1001_0020; bus.mwdata = 32'h2222_2222;
    exp_q.push_back(32'h1111_1111);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL read_in_reset: got %h want %h", bus.mrdata, exp); end
    @(negedge clk);
    bus.maddr = IO; bus.mwdata = 32'h7777; exp_q.push_back(32'h0);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL led_in_reset: got %h want %h", bus.mrdata, exp); end
    @(negedge clk); rst = 1'b0;
    bus.DM_R = 1; bus.DM_W = 0; bus.maddr = IO + 32'h4; exp_q.push_back(32'h0);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL cycle_after_reset: got %h want %h", bus.mrdata, exp); end
    n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL led_after_reset: got %h want 0000", led); end
    step(1, 1, 0, 32'h1001_0020, 0); exp_q.push_back(32'h1111_1111);
    #1; exp = exp_q.pop_front();
    n_cmp++; if (bus.mrdata !== exp) begin n_bad++; $display("FAIL ram_after_reset: got %h want %h", bus.mrdata, exp); end
  endtask

  initial begin
    bus.DM_CS = 0; bus.DM_R = 0; bus.DM_W = 0; bus.maddr = 0; bus.mwdata = 0;
    test_reset();
    test_ram();
    test_led();
    test_timer();
    test_bad_access();
    test_reset_during_store();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
